sha256_padder: RTL

Byte-stream front end for the SHA-256 compression core. It accepts message bytes over a valid/ready handshake and counts the message length. It applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length) and presents complete 512-bit blocks to the core in the core's `i_data[0:511]` ordering. It is the writer side of the core's block input and sits directly upstream of it.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_pad_fill.sv | 33 +++
 rtl/sha256_padder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: block geometry, padder FSM encoding, IV and round constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sha256_pkg;

    localparam int BLK_W     = 512;
    localparam int BLK_BYTES = 64;
    localparam int LEN_OFS   = 56;

    // Padder FSM encoding
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_EXTRA = 2'd2;

    localparam logic [0:7][31:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_pad_fill.sv
// Builds the padded block for a message's last data byte or for the trailing length-only block.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module sha256_pad_fill
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic [0:BLK_W-1] blk,
    input  logic [5:0]       idx,
    input  logic [LEN_W-1:0] len,
    input  logic             extra,
    input  logic             extra_80,
    output logic [0:BLK_W-1] pad
);

    // Keep bytes 0..idx, mark the end with 0x80, zero the rest, and append the
    // length whenever it still fits (always in the trailing block).
    always_comb begin
        pad = '0;
        for (int j = 0; j < BLK_BYTES; j++) begin
            if (extra) begin
                if (j == 0 && extra_80) pad[8*j +: 8] = 8'h80;
            end else if (6'(j) <= idx) begin
                pad[8*j +: 8] = blk[8*j +: 8];
            end else if (7'(j) == {1'b0, idx} + 7'd1) begin
                pad[8*j +: 8] = 8'h80;
            end
        end
        if (extra || idx <= 6'(LEN_OFS - 2)) pad[BLK_W-LEN_W +: LEN_W] = len;
    end

endmodule

// File: rtl/sha256_padder.sv
// Byte-stream to padded 512-bit block front end for the SHA-256 core.
// Latency: block valid the cycle after its completing byte; trailing length block 2 cycles after the prior handshake.
// Backpressure: in_ready drops while a block waits; the block is held stable until blk_ready.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [0:BLK_W-1] blk_data,
    output logic             blk_first,
    output logic             blk_last
);

    logic [1:0]       state;
    logic [5:0]       idx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;
    logic             pend_extra;
    logic             extra_80;
    logic             first_pend;
    logic [0:BLK_W-1] merged;
    logic [0:BLK_W-1] padded;
    logic             in_fire;
    logic             is_extra;

    assign in_ready = rst && (state == ST_FILL);
    assign in_fire  = in_valid && in_ready;
    assign len_nxt  = len + LEN_W'(8);
    assign is_extra = (state == ST_EXTRA);

    // Assembly buffer with the incoming byte dropped into slot idx
    always_comb begin
        merged = blk_data;
        merged[{idx, 3'b000} +: 8] = in_data;
    end

    sha256_pad_fill #(
        .LEN_W    (LEN_W)
    ) u_fill (
        .blk      (merged),
        .idx      (idx),
        .len      (is_extra ? len : len_nxt),
        .extra    (is_extra),
        .extra_80 (extra_80),
        .pad      (padded)
    );

    // Block-assembly FSM, length counter and registered block outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FILL;
            idx        <= '0;
            len        <= '0;
            pend_extra <= 1'b0;
            extra_80   <= 1'b0;
            first_pend <= 1'b1;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            blk_data   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_fire) begin
                        len <= len_nxt;
                        if (!in_last) begin
                            blk_data <= merged;
                            if (idx == 6'd63) begin
                                state     <= ST_EMIT;
                                blk_valid <= 1'b1;
                                blk_first <= first_pend;
                                blk_last  <= 1'b0;
                            end else begin
                                idx <= idx + 6'd1;
                            end
                        end else begin
                            blk_data  <= padded;
                            state     <= ST_EMIT;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            if (idx <= 6'd54) begin
                                blk_last <= 1'b1;
                            end else begin
                                // Length does not fit; it goes into a trailing block
                                blk_last   <= 1'b0;
                                pend_extra <= 1'b1;
                                extra_80   <= (idx == 6'd63);
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_valid  <= 1'b0;
                        first_pend <= 1'b0;
                        idx        <= '0;
                        if (pend_extra) begin
                            state <= ST_EXTRA;
                        end else begin
                            state <= ST_FILL;
                            if (blk_last) begin
                                len        <= '0;
                                first_pend <= 1'b1;
                            end
                        end
                    end
                end
                ST_EXTRA: begin
                    blk_data   <= padded;
                    pend_extra <= 1'b0;
                    blk_first  <= first_pend;
                    blk_last   <= 1'b1;
                    blk_valid  <= 1'b1;
                    state      <= ST_EMIT;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
